// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared mode encodings and flag bit indices for the timer block
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_FREE_X  = 2'b11
    } timer_mode_e;

    localparam int FLG_OVF = 0;
    localparam int FLG_UDF = 1;
    localparam int FLG_CMP = 2;
    localparam int NUM_FLG = 3;

endpackage

// File: rtl/timer_counter_gen_if.sv
// rtl/timer_counter_gen_if.sv - control/status bundle between register block and timer core
interface timer_counter_gen_if #(parameter int WIDTH = 16);
    logic             clk_ena;
    logic             enable;
    logic             up_down;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] reload_value;
    logic [WIDTH-1:0] compare_value;
    logic [2:0]       irq_en;
    logic [2:0]       clr_flags;
    logic [WIDTH-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             cmp_match;
    logic             running;
    logic             irq;

    modport master (
        output clk_ena, enable, up_down, mode, load, load_value, reload_value,
               compare_value, irq_en, clr_flags,
        input  count, overflow, underflow, cmp_match, running, irq
    );

    modport slave (
        input  clk_ena, enable, up_down, mode, load, load_value, reload_value,
               compare_value, irq_en, clr_flags,
        output count, overflow, underflow, cmp_match, running, irq
    );
endinterface

// File: rtl/timer_flag.sv
// rtl/timer_flag.sv - one sticky status bit, clear wins over a same-cycle set
module timer_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= 1'b0;
        else if (clr)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
    end

endmodule

// File: rtl/timer_counter_gen.sv
// rtl/timer_counter_gen.sv - up/down timer with free-run, auto-reload, one-shot and sticky flags
module timer_counter_gen
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    timer_counter_gen_if.slave bus
);

    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   count_d;
    logic               running_q;
    logic               running_d;
    logic               tick;
    logic               wrap_up;
    logic               wrap_dn;
    logic [NUM_FLG-1:0] flag_set;
    logic [NUM_FLG-1:0] flag_q;

    // Wrap is judged on the current value at the counting edge itself.
    always_comb begin
        tick      = bus.enable & bus.clk_ena & running_q & ~bus.load;
        wrap_up   = tick &  bus.up_down & (count_q == MAXV);
        wrap_dn   = tick & ~bus.up_down & (count_q == '0);
        count_d   = count_q;
        running_d = running_q;

        if (bus.load) begin
            count_d   = bus.load_value;
            running_d = 1'b1;
        end else if (tick) begin
            if (wrap_up || wrap_dn) begin
                case (timer_mode_e'(bus.mode))
                    MODE_RELOAD:  count_d = bus.reload_value;
                    MODE_ONESHOT: begin
                        count_d   = bus.reload_value;
                        running_d = 1'b0;
                    end
                    default:      count_d = wrap_up ? '0 : MAXV;
                endcase
            end else if (bus.up_down) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end

        flag_set          = '0;
        flag_set[FLG_OVF] = wrap_up;
        flag_set[FLG_UDF] = wrap_dn;
        flag_set[FLG_CMP] = tick & (count_d == bus.compare_value);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            running_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

    for (genvar i = 0; i < NUM_FLG; i++) begin : g_flag
        timer_flag u_flag (
            .clk   (clk),
            .rst_n (rst_n),
            .set   (flag_set[i]),
            .clr   (bus.clr_flags[i]),
            .q     (flag_q[i])
        );
    end

    assign bus.count     = count_q;
    assign bus.running   = running_q;
    assign bus.overflow  = flag_q[FLG_OVF];
    assign bus.underflow = flag_q[FLG_UDF];
    assign bus.cmp_match = flag_q[FLG_CMP];
    assign bus.irq       = |(flag_q & bus.irq_en);

endmodule

// File: tb/tb_timer_counter_gen.sv
// tb/tb_timer_counter_gen.sv - directed vector bench for timer_counter_gen at WIDTH 8 and 16
module tb_timer_counter_gen;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    timer_counter_gen_if #(.WIDTH(8))  a_if ();
    timer_counter_gen_if #(.WIDTH(16)) b_if ();

    timer_counter_gen #(.WIDTH(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    timer_counter_gen #(.WIDTH(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] lv;
        logic       ena;
        logic       en;
        logic       ud;
        logic [1:0] mode;
        logic [7:0] rv;
        logic [7:0] cv;
        logic [2:0] ien;
        logic [2:0] clr;
        logic [7:0] e_cnt;
        logic [2:0] e_fl;
        logic       e_run;
        logic       e_irq;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, logic ld, logic [7:0] lv, logic ena, logic en,
                                logic ud, logic [1:0] mode, logic [7:0] rv, logic [7:0] cv,
                                logic [2:0] ien, logic [2:0] clr, logic [7:0] e_cnt,
                                logic [2:0] e_fl, logic e_run, logic e_irq);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.ena = ena; v.en = en; v.ud = ud;
        v.mode = mode; v.rv = rv; v.cv = cv; v.ien = ien; v.clr = clr;
        v.e_cnt = e_cnt; v.e_fl = e_fl; v.e_run = e_run; v.e_irq = e_irq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_b(input logic ld, input logic [15:0] lv, input logic ena);
        b_if.load    = ld;
        b_if.load_value = lv;
        b_if.clk_ena = ena;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;

        b_if.clk_ena = 1'b0; b_if.enable = 1'b1; b_if.up_down = 1'b1;
        b_if.mode = 2'b10; b_if.load = 1'b0; b_if.load_value = '0;
        b_if.reload_value = 16'h1234; b_if.compare_value = 16'hAAAA;
        b_if.irq_en = 3'b000; b_if.clr_flags = 3'b000;

        //            rst ld lv    ena en ud mode  rv     cv     ien     clr   | cnt   fl     run irq
        vt.push_back(mk(0, 0, 8'h00, 0, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'h00, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'hFE, 0, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'hFE, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'hFF, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'h00, 3'b001, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 2'd0, 8'h00, 8'h80, 3'b001, 3'b000, 8'h00, 3'b001, 1, 1));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 2'd0, 8'h00, 8'h80, 3'b110, 3'b000, 8'h00, 3'b001, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 2'd0, 8'h00, 8'h80, 3'b001, 3'b001, 8'h00, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'h01, 0, 1, 0, 2'd1, 8'h05, 8'h80, 3'b000, 3'b000, 8'h01, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 0, 2'd1, 8'h05, 8'h80, 3'b000, 3'b000, 8'h00, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 0, 2'd1, 8'h05, 8'h80, 3'b000, 3'b000, 8'h05, 3'b010, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 0, 2'd1, 8'h05, 8'h80, 3'b000, 3'b010, 8'h05, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'h10, 0, 1, 1, 2'd0, 8'h00, 8'h10, 3'b000, 3'b000, 8'h10, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'h0F, 0, 1, 1, 2'd0, 8'h00, 8'h10, 3'b000, 3'b000, 8'h0F, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 2'd0, 8'h00, 8'h10, 3'b100, 3'b000, 8'h10, 3'b100, 1, 1));
        vt.push_back(mk(1, 1, 8'h0F, 0, 1, 1, 2'd0, 8'h00, 8'h10, 3'b100, 3'b000, 8'h0F, 3'b100, 1, 1));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 2'd0, 8'h00, 8'h10, 3'b100, 3'b100, 8'h10, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'h01, 0, 1, 0, 2'd1, 8'h10, 8'h10, 3'b000, 3'b000, 8'h01, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 0, 2'd1, 8'h10, 8'h10, 3'b000, 3'b000, 8'h00, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 0, 2'd1, 8'h10, 8'h10, 3'b100, 3'b000, 8'h10, 3'b110, 1, 1));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 0, 2'd1, 8'h10, 8'h10, 3'b100, 3'b111, 8'h10, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'h00, 0, 1, 0, 2'd3, 8'h10, 8'h80, 3'b000, 3'b000, 8'h00, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 0, 2'd3, 8'h10, 8'h80, 3'b000, 3'b000, 8'hFF, 3'b010, 1, 0));
        vt.push_back(mk(1, 1, 8'hFF, 0, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b010, 8'hFF, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'h33, 1, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'h33, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 0, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'h33, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'h34, 3'b000, 1, 0));
        vt.push_back(mk(1, 1, 8'hFF, 0, 1, 1, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'hFF, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 2'd0, 8'h00, 8'h80, 3'b111, 3'b000, 8'h00, 3'b001, 1, 1));
        vt.push_back(mk(0, 1, 8'hAA, 1, 1, 1, 2'd0, 8'h00, 8'h80, 3'b111, 3'b000, 8'h00, 3'b000, 1, 0));
        vt.push_back(mk(1, 0, 8'h00, 1, 1, 0, 2'd0, 8'h00, 8'h80, 3'b000, 3'b000, 8'hFF, 3'b010, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            rst_n              = vt[i].rst;
            a_if.load          = vt[i].ld;
            a_if.load_value    = vt[i].lv;
            a_if.clk_ena       = vt[i].ena;
            a_if.enable        = vt[i].en;
            a_if.up_down       = vt[i].ud;
            a_if.mode          = vt[i].mode;
            a_if.reload_value  = vt[i].rv;
            a_if.compare_value = vt[i].cv;
            a_if.irq_en        = vt[i].ien;
            a_if.clr_flags     = vt[i].clr;
            step();
            chk($sformatf("v%0d count", i), 32'(a_if.count), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d flags", i),
                32'({a_if.cmp_match, a_if.underflow, a_if.overflow}), 32'(vt[i].e_fl));
            chk($sformatf("v%0d running", i), 32'(a_if.running), 32'(vt[i].e_run));
            chk($sformatf("v%0d irq", i), 32'(a_if.irq), 32'(vt[i].e_irq));
        end

        // One-shot expiry at WIDTH 16, hold while stopped, then re-arm by load.
        a_if.clk_ena = 1'b0;
        a_if.load    = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("b reset count", 32'(b_if.count), 32'h0);
        chk("b reset running", 32'(b_if.running), 32'h1);
        drive_b(1'b1, 16'hFFFF, 1'b0);
        chk("b load count", 32'(b_if.count), 32'hFFFF);
        drive_b(1'b0, 16'h0000, 1'b1);
        chk("b expire count", 32'(b_if.count), 32'h1234);
        chk("b expire running", 32'(b_if.running), 32'h0);
        chk("b expire overflow", 32'(b_if.overflow), 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive_b(1'b0, 16'h0000, 1'b1);
            chk($sformatf("b hold%0d count", k), 32'(b_if.count), 32'h1234);
            chk($sformatf("b hold%0d running", k), 32'(b_if.running), 32'h0);
        end
        drive_b(1'b1, 16'h0000, 1'b1);
        chk("b rearm count", 32'(b_if.count), 32'h0000);
        chk("b rearm running", 32'(b_if.running), 32'h1);
        chk("b rearm overflow sticky", 32'(b_if.overflow), 32'h1);
        drive_b(1'b0, 16'h0000, 1'b1);
        chk("b resume count", 32'(b_if.count), 32'h0001);
        drive_b(1'b0, 16'h0000, 1'b1);
        chk("b resume2 count", 32'(b_if.count), 32'h0002);
        chk("b resume running", 32'(b_if.running), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_counter_gen.md
# timer_counter_gen

Parametrised general-purpose timer/counter: WIDTH-bit up/down counter with free-run, auto-reload and one-shot modes, a compare-match event, and three sticky status flags (overflow, underflow, compare) with per-flag interrupt masking. It sits behind the timer register block. It consumes the prescaler's `clk_ena` strobe and feeds a single `irq` line to the interrupt controller. Wrap detection is done on the counting edge itself, so no delayed-copy comparison is used.

## Interface
- `WIDTH`, 16: counter width; legal 2..32.
- `MAXV`, derived `{WIDTH{1'b1}}`: terminal count (not overridable).

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clk_ena`  in  1  prescaled count strobe (one-cycle pulse).
- `enable`  in  1  count enable.
- `up_down`  in  1  1 = count up, 0 = count down.
- `mode`  in  2  00 free-run, 01 auto-reload, 10 one-shot, 11 treated as free-run.
- `load`  in  1  load `load_value` into counter, re-arm.
- `load_value`  in  WIDTH  value written by `load`.
- `reload_value`  in  WIDTH  value written on wrap in modes 01/10.
- `compare_value`  in  WIDTH  compare-match target.
- `irq_en`  in  3  interrupt mask {cmp, underflow, overflow}.
- `clr_flags`  in  3  one-cycle clear {cmp, underflow, overflow}.
- `count`  out  WIDTH  current counter value.
- `overflow`  out  1  sticky: up-count wrapped from MAXV.
- `underflow`  out  1  sticky: down-count wrapped from 0.
- `cmp_match`  out  1  sticky: a tick produced `count == compare_value`.
- `running`  out  1  armed; 0 after a one-shot expiry.
- `irq`  out  1  `|({cmp_match,underflow,overflow} & irq_en)`, combinational from the flag registers.

## Operation
- Reset: `count`=0, all flags 0, `running`=1.
- `tick = enable & clk_ena & running & ~load`.
- Priority, highest first: `load` > tick > hold.
- `load`:
  - `count <= load_value`, `running <= 1`.
  - Never sets any flag, even if `load_value` equals `compare_value` or a terminal value.
- Wrap event: a tick with (`up_down`=1 and `count==MAXV`) or (`up_down`=0 and `count==0`).
  - Sets `overflow` or `underflow` respectively, in all modes.
- Next value on a wrap:
  - free-run: 0 (up) / MAXV (down).
  - auto-reload: `reload_value`.
  - one-shot: `reload_value`, and `running <= 0`.
- Non-wrap tick: `count` ±1 modulo 2^WIDTH.
- Compare: `cmp_match` sets when a tick's next value equals `compare_value`. This includes a reloaded value.
- Flags are sticky. For each flag, a `clr_flags` bit in the same cycle as its set event wins (flag reads 0).
- Mode or direction changes take effect on the next tick; no flag is generated by the change itself.
- One-shot, stopped: ticks are ignored. Only `load` (or reset) re-arms.

## Timing
- `count`, flags and `running` are registered. They update on the edge where tick/load is sampled high, with a latency of 1 clock.
- `irq` follows the flag registers with no added latency.
- Back-to-back `clk_ena` pulses (every cycle) must count every cycle and must detect every wrap.
- Reset mid-count: all state takes reset values on the next edge regardless of other inputs.

## Structure
- Shared package `timer_pkg`:
  - mode encodings `MODE_FREE`, `MODE_RELOAD`, `MODE_ONESHOT`.
  - flag bit indices `FLG_OVF=0`, `FLG_UDF=1`, `FLG_CMP=2`.
- Sub-module `timer_flag`: one sticky set/clear bit with clear-wins priority and synchronous reset. It is instantiated three times.
- The counter datapath and next-value mux stay in the top module.

## Test plan
- WIDTH=8, free-run up, `load_value`=0xFE, `clk_ena` every cycle: count FE→FF→00. `overflow`=1 on the edge count becomes 00. `irq`=1 only if `irq_en[0]`=1.
- WIDTH=8, auto-reload down, `reload_value`=0x05, load 0x01: ticks 01→00→05. `underflow` set on the 00→05 edge, not before.
- WIDTH=16, one-shot up, `reload_value`=0x1234, load 0xFFFF: one tick gives count=0x1234, `running`=0, `overflow`=1. Further ticks hold 0x1234. `load` 0x0000 re-arms and counting resumes.
- `compare_value`=0x10, load 0x10: `cmp_match` stays 0. Load 0x0F, then one up tick: `cmp_match`=1. Assert `clr_flags[2]` in the same cycle as a second match: the flag reads 0.
- Simultaneous `load` and wrap condition (count=MAXV, up, tick): `count=load_value`, no `overflow`. Then `rst_n`=0 for one cycle mid-count: `count`=0, flags=0, `running`=1.
